sdram_port_bridge: RTL

//  Converts one SDRAM client port (ROM or cartridge) from core read strobes plus the

---
 rtl/sdram_bridge_pkg.sv | 11 +
 rtl/sdram_port_bridge_if.sv | 11 +
 rtl/sdram_req_hold.sv | 25 ++
 rtl/sdram_port_bridge.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: shared state encoding and request record for sdram_port_bridge
package sdram_bridge_pkg;
  localparam int MEM_AW_DEF = 22;
  localparam int SRC_AW = 25;
  typedef enum logic [1:0] {SYNC, IDLE, BUSY} state_t;
  typedef struct packed {
    logic [SRC_AW-1:0] addr;
    logic [7:0]        din;
    logic              we;
  } req_t;
endpackage

// File: rtl/sdram_port_bridge_if.sv
// sdram_port_bridge_if: toggle req/ack bus between a port bridge and the SDRAM controller
interface sdram_port_bridge_if #(parameter int AW = 22);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_req;
  logic          mem_ack;
  logic [15:0]   mem_dout;
  modport master(output mem_addr, mem_din, mem_we, mem_req, input mem_ack, mem_dout);
  modport slave(input mem_addr, mem_din, mem_we, mem_req, output mem_ack, mem_dout);
endinterface

// File: rtl/sdram_req_hold.sv
// sdram_req_hold: one-entry request buffer with load/overwrite, clear and full flag
module sdram_req_hold
  import sdram_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clr_i,
  input  req_t d_i,
  output req_t q_o,
  output logic full_o
);
  req_t q_q;
  logic full_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) q_q <= d_i;
      full_q <= load_i | (full_q & ~clr_i);
    end
  assign q_o = q_q;
  assign full_o = full_q;
endmodule

// File: rtl/sdram_port_bridge.sv
// sdram_port_bridge: core read strobes / ioctl bytes to SDRAM toggle req/ack with one-entry hold.
// Optional ack watchdog enabled by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_port_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int MEM_AW  = MEM_AW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                dl_active,
  input  logic                ioctl_wr,
  input  logic [SRC_AW-1:0]   ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  input  logic                core_stb,
  input  logic [15:0]         core_addr,
  output logic [15:0]         core_dout,
  output logic                core_valid,
  sdram_port_bridge_if.master mem,
  output logic                err_timeout
);
  state_t state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic we_q, we_d, req_q, req_d, valid_q, valid_d, wait_q, wait_d;
  logic [15:0] dout_q, dout_d;
  logic wr_ev, rd_ev, new_ev, done, tmo;
  logic hold_load, hold_clr, hold_full, hold_full_nxt;
  req_t new_r, iss_r, hold_q;
  logic unused_bits;
  assign wr_ev = dl_active & ioctl_wr;
  assign rd_ev = ~dl_active & core_stb;
  assign new_ev = wr_ev | rd_ev;
  assign done = mem.mem_ack == req_q;
  assign new_r = wr_ev ? '{addr: ioctl_addr, din: ioctl_dout, we: 1'b1}
                       : '{addr: SRC_AW'({core_addr, 1'b0}), din: 8'h00, we: 1'b0};
  assign iss_r = hold_full ? hold_q : new_r;
  assign unused_bits = ^{iss_r.addr[SRC_AW-1:MEM_AW], TIMEOUT[0]};
  sdram_req_hold u_hold (
    .clk   (clk_sys),
    .rst   (reset),
    .load_i(hold_load),
    .clr_i (hold_clr),
    .d_i   (new_r),
    .q_o   (hold_q),
    .full_o(hold_full)
  );
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign tmo = cnt_q == 16'(TIMEOUT - 1);
  always_comb begin
    cnt_d = (state_q == BUSY && !done) ? cnt_q + 16'd1 : 16'd0;
    err_d = err_q | (state_q == BUSY && !done && tmo);
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign err_timeout = err_q;
`else
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    din_d = din_q;
    we_d = we_q;
    req_d = req_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    hold_load = 1'b0;
    hold_clr = 1'b0;
    case (state_q)
      SYNC: begin
        req_d = mem.mem_ack;
        state_d = IDLE;
      end
      IDLE: if (hold_full || new_ev) begin
        addr_d = iss_r.addr[MEM_AW-1:0];
        din_d = iss_r.din;
        we_d = iss_r.we;
        req_d = ~req_q;
        state_d = BUSY;
        hold_clr = hold_full;
        hold_load = hold_full && new_ev;
      end
      BUSY: begin
        // a newer read replaces a held read; anything else only fills an empty hold
        hold_load = new_ev && (!hold_full || (rd_ev && !hold_q.we));
        if (done) begin
          state_d = IDLE;
          dout_d = we_q ? dout_q : mem.mem_dout;
          valid_d = !we_q;
        end else if (tmo) begin
          req_d = mem.mem_ack;
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
    hold_full_nxt = hold_load | (hold_full & ~hold_clr);
    wait_d = (state_d != IDLE) | hold_full_nxt;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q <= SYNC;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      req_q <= 1'b0;
      dout_q <= '0;
      valid_q <= 1'b0;
      wait_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
      req_q <= req_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      wait_q <= wait_d;
    end
  assign mem.mem_addr = addr_q;
  assign mem.mem_din = din_q;
  assign mem.mem_we = we_q;
  assign mem.mem_req = req_q;
  assign ioctl_wait = wait_q;
  assign core_dout = dout_q;
  assign core_valid = valid_q;
endmodule
